// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// UART_TX_DEPTH is the default FIFO depth used by uart_tx_ctrl.
package uart_tx_ctrl_pkg;

    localparam int UART_TX_DEPTH = 16;

    typedef logic [7:0] uart_byte_t;

    // Width needed to hold a down-counter loaded with n-1 (at least 1 bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers and registered level/full.
// A push while full is taken only when a pop happens in the same cycle.
module uart_tx_fifo
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DEPTH = UART_TX_DEPTH
) (
    input  logic                   clk,
    input  logic                   rstd,
    input  logic                   push,
    input  uart_byte_t             wr_data,
    input  logic                   pop,
    output uart_byte_t             rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          do_push, do_pop;
    uart_byte_t    mem_q [DEPTH];

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full_q || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        level_d = wr_ptr_d - rd_ptr_d;
        full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0])
               && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    end

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign full    = full_q;
    assign level   = level_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit scheduler: CPU store FIFO, start/ack/send/gap FSM.
// Define UART_TX_CTRL_STALL_EN to stall writes to a full FIFO instead of dropping them.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DEPTH      = UART_TX_DEPTH,
    parameter int GAP_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rstd,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   stall,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACK  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam int GW         = cnt_w(GAP_CYCLES);
    localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [GW-1:0] GAP_LOAD = GAP_LOAD_I[GW-1:0];

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          ovf_q, ovf_d;
    logic          tx_start_q, tx_start_d;
    uart_byte_t    tx_data_q, tx_data_d;
    uart_byte_t    rd_data;
    logic          empty, pop, push, refused, drop;

    assign refused = wr_en && full && !pop;
    assign push    = wr_en && !refused;

`ifdef UART_TX_CTRL_STALL_EN
    assign stall = refused;
    assign drop  = 1'b0;
`else
    assign stall = 1'b0;
    assign drop  = refused;
`endif

    uart_tx_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstd    (rstd),
        .push    (push),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            state_q    <= S_IDLE;
            gap_q      <= '0;
            ovf_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            ovf_q      <= ovf_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (tx_busy) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The busy check on pop keeps a post-reset start off a frame still on the line.
    always_comb begin
        pop        = (state_q == S_IDLE) && !empty && !tx_busy;
        tx_start_d = pop;
        tx_data_d  = pop ? rd_data : tx_data_q;
        ovf_d      = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    assign overflow = ovf_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit scheduler between the CPU's memory-mapped UART store path and the byte-serial UART transmitter. CPU stores to `UART_ADDR` push bytes into a local FIFO; an FSM pops them one at a time, starts the transmitter, waits for it to finish, and enforces a programmable inter-byte gap. The CPU can issue back-to-back stores without losing characters while the line is still busy.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries, power of 2, minimum 2.
- `GAP_CYCLES`, 0: idle clocks inserted after each byte completes. 0 means no gap.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rstd` in 1: reset, asynchronous, active-high.
- `wr_en` in 1: CPU store decoded to `UART_ADDR`.
- `wr_data` in 8: store byte, `rs2[7:0]`.
- `stall` out 1: combinational; write refused this cycle (see Configuration).
- `full` out 1: registered; level == `DEPTH`.
- `level` out clog2(`DEPTH`)+1: registered FIFO occupancy.
- `overflow` out 1: sticky flag; a write was dropped.
- `ovf_clr` in 1: clears `overflow`.
- `tx_start` out 1: one-cycle pulse to the transmitter.
- `tx_data` out 8: byte to send; held stable from `tx_start` until the next pop.
- `tx_busy` in 1: high while the transmitter shifts a frame.

## Operation
- Write accept: `wr_en && (!full || pop)`, where `pop` is the same-cycle FIFO read.
- A write and a pop in the same cycle while full are both accepted; level does not change.
- Write while full with no pop: refused; behaviour is set by the macro below.
- FSM states:
  - IDLE: if FIFO not empty and `!tx_busy`, pop the head into `tx_data`, set `tx_start`, go to ACK.
  - ACK: wait for `tx_busy`=1, then go to SEND. `tx_start` is high only on the first ACK cycle.
  - SEND: wait for `tx_busy`=0. Then go to GAP, loading the counter with `GAP_CYCLES`-1, or go to IDLE if `GAP_CYCLES`=0.
  - GAP: decrement the counter; at 0, go to IDLE.
- Pointers are clog2(`DEPTH`)+1 bits wide; the extra MSB is a wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
- `overflow` behaviour:
  - Set on any refused write in non-stall mode.
  - `ovf_clr` clears it.
  - If a set and a clear happen in the same cycle, set wins.
- Reset values:
  - State IDLE, FIFO empty, `level`=0.
  - `full`=0, `overflow`=0, `tx_start`=0, `tx_data`=0, gap counter 0.
- Reset mid-operation: everything above is cleared immediately (asynchronous). A frame already in the transmitter finishes on its own. The IDLE check on `tx_busy` prevents a colliding start afterwards.

## Timing
- Empty FIFO, state IDLE, `tx_busy`=0, write in cycle N:
  - `level`=1 in N+1; IDLE pops in N+1.
  - `tx_start`=1 and `tx_data` valid in N+2; `level`=0 in N+2.
- Write-to-start latency is 2 cycles.
- Back-to-back bytes: the next `tx_start` comes `GAP_CYCLES`+2 cycles after `tx_busy` falls (SEND→GAP/IDLE, IDLE pop, pulse).
- `stall` is combinational from `wr_en`, `full` and `pop`, so it can hold the CPU's PC update in the same cycle.
- `level` and `full` update one cycle after the accepting edge.

## Configuration
- `UART_TX_CTRL_STALL_EN`:
  - Defined: a write to a full FIFO with no pop raises `stall`. The write is not accepted, and the CPU repeats the store next cycle. `overflow` is never set.
  - Undefined: `stall` is tied to 0. A write to a full FIFO with no pop is dropped and sets `overflow`.

## Structure
- Shared `define.vh` holds `UART_ADDR` (already there) and the new `UART_TX_DEPTH` default.
- FSM state encodings are localparams inside the block and are not shared.
- One sub-module, `uart_tx_fifo`: synchronous FIFO with push/pop/full/empty/level, parameter `DEPTH`, asynchronous active-high reset on `rstd`.
- The FSM, gap counter and `overflow` flag stay in `uart_tx_ctrl`.

## Test plan
- Single byte: write 0x41 at cycle 10 with `tx_busy`=0 → `tx_start` pulse at cycle 12 with `tx_data`=0x41; `level` goes 0→1→0.
- Burst: `GAP_CYCLES`=3, 4 writes (0x10–0x13) on consecutive cycles, transmitter model busy 20 cycles per byte → 4 starts in order, each exactly 5 cycles after the previous `tx_busy` fall.
- Overflow, macro undefined: `DEPTH`=4, `tx_busy` held 1, 6 writes → `level`=4, `full`=1, `overflow`=1, 2 bytes dropped, first 4 bytes sent in order. `ovf_clr` → `overflow`=0.
- Stall, macro defined: same stimulus as the overflow case → `stall`=1 on writes 5–6. CPU model retries; all 6 bytes are sent and `overflow` stays 0.
- Full with simultaneous push/pop: full FIFO, `tx_busy` falls so IDLE pops while `wr_en`=1 → write accepted, `level` stays 4, `stall`=0.
- Reset mid-frame: assert `rstd` during SEND with `level`=3 → all outputs at reset values asynchronously. After release, no `tx_start` until `tx_busy`=0 and a new write arrives.
